dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, meaning log2 of the memory depth in 32-bit words (1024 words).
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, meaning the extra response latency in cycles (legal range 0..15).
REQ-003 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port mem_addr, input, 32 bits: byte address of the request.
REQ-006 Port mem_write_data, input, 32 bits: store data, lane-aligned as presented.
REQ-007 Port mem_write_en, input, 1 bit: write request.
REQ-008 Port mem_read_en, input, 1 bit: read request.
REQ-009 Port mem_byte_enable, input, 4 bits: per-lane write enables; bit i selects bits [8i+7:8i].
REQ-010 Port mem_read_data, output, 32 bits: registered read data, full word.
REQ-011 Port mem_ready, output, 1 bit: one-cycle completion pulse for the accepted request.
REQ-012 Port mem_busy, output, 1 bit: high while a request is in progress; new requests are not accepted.

Function
REQ-013 The block SHALL contain a 2^ADDR_WIDTH x 32-bit storage array indexed by mem_addr[ADDR_WIDTH+1:2].
REQ-014 Address bits above ADDR_WIDTH+1 SHALL be ignored, so addresses wrap modulo the memory size.
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 In IDLE, a rising edge with mem_read_en or mem_write_en high SHALL accept the request and capture addr, data, byte enables and operation.
REQ-017 On acceptance, the FSM SHALL go to WAIT if WAIT_STATES>0, otherwise directly to RESP.
REQ-018 WAIT SHALL last exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then go to RESP.
REQ-019 RESP SHALL last exactly one cycle with mem_ready=1, then return to IDLE.
REQ-020 mem_ready SHALL rise WAIT_STATES+1 cycles after the accepting edge.
REQ-021 mem_busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-022 Requests presented while mem_busy=1 SHALL be ignored, not queued.
REQ-023 A write SHALL update only the lanes whose byte-enable bit is set, on the edge entering RESP.
REQ-024 A write with mem_byte_enable=4'b0000 SHALL leave memory unchanged but still complete the handshake.
REQ-025 A read SHALL load mem_read_data with the full word on the edge entering RESP.
REQ-026 mem_read_data SHALL hold its value until the next read completes; writes SHALL not change it.
REQ-027 If mem_read_en and mem_write_en are both high at acceptance, the request SHALL be treated as a write only.
REQ-028 Back-to-back requests SHALL be accepted no earlier than the first IDLE cycle after RESP, giving a minimum spacing of WAIT_STATES+2 cycles.

Reset
REQ-029 While rst_n=0, the block SHALL force state=IDLE, counter=0, mem_ready=0, mem_busy=0 and mem_read_data=0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset asserted mid-request SHALL abort the request, and a pending write SHALL NOT be committed.

Configuration
REQ-032 With DMEM_MISALIGN_ERR_EN defined, the block SHALL add output mem_error (1 bit, reset value 0).
REQ-033 With DMEM_MISALIGN_ERR_EN defined, a misaligned request SHALL suppress the write, return mem_read_data=0, and pulse mem_error together with mem_ready.
REQ-034 A request SHALL count as misaligned when byte_enable=1111 with addr[1:0]!=0, or byte_enable=0011 with addr[0]=1.
REQ-035 Without DMEM_MISALIGN_ERR_EN, the mem_error port SHALL be absent and mem_addr[1:0] SHALL be ignored.

Verification
REQ-036 WAIT_STATES=1: write 0xDEADBEEF, byte_enable=1111 to 0x100, then read 0x100 -> each mem_ready arrives 2 cycles after acceptance, and mem_read_data=0xDEADBEEF.
REQ-037 Word 0x100 holds 0xDEADBEEF; write 0x000000AA with byte_enable=0001, then read -> mem_read_data=0xDEADBEAA.
REQ-038 WAIT_STATES=1: assert mem_read_en on the cycle after acceptance while busy -> request ignored; exactly one mem_ready pulse.
REQ-039 ADDR_WIDTH=10: write 0x12345678 to 0x1000, then read 0x0000 -> mem_read_data=0x12345678 (wrap).
REQ-040 During WAIT of a write of 0x55 to 0x200, pulse rst_n low -> outputs return to 0, no mem_ready, and word 0x200 is unchanged.
REQ-041 With DMEM_MISALIGN_ERR_EN: word write to 0x102 -> mem_error=1 with mem_ready, and word 0x100 is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one read/write at a time and answers after WAIT_STATES extra cycles.
// Optional misaligned-access error reporting is enabled by defining DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_write_en,
    input  logic        mem_read_en,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_busy
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        mem_error
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                r_state;
    state_t                w_nextState;
    logic [3:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic                  r_isWrite;
    logic                  r_misaligned;
    logic [31:0]           r_readData;
    logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

    logic                  w_accept;
    logic                  w_enterResp;
    logic                  w_reqMis;
    logic [ADDR_WIDTH-1:0] w_curIdx;
    logic [31:0]           w_curWdata;
    logic [3:0]            w_curBe;
    logic                  w_curWrite;
    logic                  w_curMis;
    logic                  w_unused;

    assign w_accept = (r_state == IDLE) && (mem_read_en || mem_write_en);

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_reqMis = ((mem_byte_enable == 4'b1111) && (mem_addr[1:0] != 2'b00)) ||
                      ((mem_byte_enable == 4'b0011) && mem_addr[0]);
    assign mem_error = (r_state == RESP) && r_misaligned;
`else
    assign w_reqMis = 1'b0;
`endif

    assign w_unused = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

    // With zero wait states RESP is entered on the accepting edge, so the live inputs must be used then.
    assign w_curIdx   = (r_state == IDLE) ? mem_addr[ADDR_WIDTH+1:2] : r_idx;
    assign w_curWdata = (r_state == IDLE) ? mem_write_data : r_wdata;
    assign w_curBe    = (r_state == IDLE) ? mem_byte_enable : r_be;
    assign w_curWrite = (r_state == IDLE) ? mem_write_en : r_isWrite;
    assign w_curMis   = (r_state == IDLE) ? w_reqMis : r_misaligned;

    assign w_enterResp   = (w_nextState == RESP) && (r_state != RESP);
    assign mem_read_data = r_readData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        mem_ready   = 1'b0;
        mem_busy    = 1'b1;
        case (r_state)
            IDLE: begin
                mem_busy = 1'b0;
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_nextState = RESP;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_count <= 4'd1) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                mem_ready   = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Request capture, wait counter and the registered read-data output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= 4'd0;
            r_idx        <= '0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_isWrite    <= 1'b0;
            r_misaligned <= 1'b0;
            r_readData   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_count      <= WAIT_INIT;
                r_idx        <= mem_addr[ADDR_WIDTH+1:2];
                r_wdata      <= mem_write_data;
                r_be         <= mem_byte_enable;
                r_isWrite    <= mem_write_en;
                r_misaligned <= w_reqMis;
            end else if (r_state == WAIT) begin
                r_count <= r_count - 4'd1;
            end
            if (w_enterResp) begin
                if (w_curMis) begin
                    r_readData <= 32'd0;
                end else if (!w_curWrite) begin
                    r_readData <= r_mem[w_curIdx];
                end
            end
        end
    end

    // Storage is never reset; a reset during WAIT keeps the FSM out of RESP so the write is dropped.
    always_ff @(posedge clk) begin
        if (w_enterResp && w_curWrite && !w_curMis) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (w_curBe[lane]) begin
                    r_mem[w_curIdx][8*lane +: 8] <= w_curWdata[8*lane +: 8];
                end
            end
        end
    end

endmodule
